// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and the
// transmitter acknowledge timeout.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD      = 2'd1,
      WAIT_ACK  = 2'd2,
      WAIT_DONE = 2'd3
   } arb_state_t;

   localparam int ACK_TIMEOUT = 4;
   localparam int ACK_TW      = $clog2(ACK_TIMEOUT);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or above (last + 1),
// wrapping, returned one-hot.
module rr_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] last,
   output logic [N_REQ-1:0]         winner
);

   localparam int IW = $clog2(N_REQ);

   logic [IW-1:0] idx;

   // Walk offsets from farthest to nearest so the nearest set bit wins.
   always_comb begin
      winner = '0;
      idx    = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         idx = IW'((int'(last) + k) % N_REQ);
         if (req[idx]) begin
            winner      = '0;
            winner[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arb.sv
// Arbitrates N_REQ byte-stream requesters onto one UART transmitter core,
// with round-robin grant, per-grant burst limit and ack timeout.
//
// state     | meaning
// IDLE      | no owner; pick round-robin winner when any request is valid
// LOAD      | owner holds grant; accept next byte once transmitter is free
// WAIT_ACK  | byte launched; wait for tx_busy to rise (bounded)
// WAIT_DONE | wait for transmitter to finish; release or load next byte
module uart_tx_arb
   import uart_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int MAX_BURST = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   req_ready,
   output logic [N_REQ-1:0]   grant,
   output logic [7:0]         tx_data,
   output logic               tx_start,
   input  logic               tx_busy
);

   localparam int IW = $clog2(N_REQ);
   localparam int BW = $clog2(MAX_BURST + 1);

   arb_state_t        state_q, state_d;
   logic [N_REQ-1:0]  grant_q, grant_d;
   logic [IW-1:0]     owner_q, owner_d;
   logic [BW-1:0]     burst_q, burst_d;
   logic [ACK_TW-1:0] timer_q, timer_d;
   logic              last_q, last_d;
   logic [7:0]        data_q, data_d;
   logic              start_q, start_d;

   logic [N_REQ-1:0]  winner;
   logic [IW-1:0]     g_idx;
   logic              sel_valid, sel_last;
   logic [7:0]        sel_data;

   rr_arbiter #(.N_REQ(N_REQ)) u_rr (
      .req    (req_valid),
      .last   (owner_q),
      .winner (winner)
   );

   // One-hot mux of the current owner's inputs.
   always_comb begin
      g_idx    = '0;
      sel_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_q[i]) g_idx = IW'(i);
         sel_data = sel_data | (req_data[8*i +: 8] & {8{grant_q[i]}});
      end
      sel_valid = |(req_valid & grant_q);
      sel_last  = |(req_last & grant_q);
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      owner_d   = owner_q;
      burst_d   = burst_q;
      timer_d   = timer_q;
      last_d    = last_q;
      data_d    = data_q;
      start_d   = 1'b0;
      req_ready = '0;
      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               grant_d = winner;
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (!tx_busy) begin
               if (sel_valid) begin
                  req_ready = grant_q;
                  data_d    = sel_data;
                  start_d   = 1'b1;
                  last_d    = sel_last;
                  if (burst_q != BW'(MAX_BURST)) burst_d = burst_q + 1'b1;
                  timer_d   = ACK_TW'(ACK_TIMEOUT - 1);
                  state_d   = WAIT_ACK;
               end else begin
                  grant_d = '0;
                  owner_d = g_idx;
                  burst_d = '0;
                  state_d = IDLE;
               end
            end
         end
         WAIT_ACK: begin
            if (tx_busy || timer_q == '0) state_d = WAIT_DONE;
            else                          timer_d = timer_q - 1'b1;
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               if (last_q || burst_q == BW'(MAX_BURST)) begin
                  grant_d = '0;
                  owner_d = g_idx;
                  burst_d = '0;
                  state_d = IDLE;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         owner_q <= IW'(N_REQ - 1);
         burst_q <= '0;
         timer_q <= '0;
         last_q  <= 1'b0;
         data_q  <= 8'h00;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         burst_q <= burst_d;
         timer_q <= timer_d;
         last_q  <= last_d;
         data_q  <= data_d;
         start_q <= start_d;
      end
   end

   assign grant    = grant_q;
   assign tx_data  = data_q;
   assign tx_start = start_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: vector table for single-cycle behaviour,
// hand sequences for arbitration order, burst limit, back-to-back and reset.
module tb_uart_tx_arb;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_last  = '0;
   logic [8*N-1:0] req_data  = '0;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   grant;
   logic [7:0]     tx_data;
   logic           tx_start;
   logic           tx_busy;

   logic man_busy  = 1'b0;
   logic auto_busy = 1'b0;
   int   busy_len  = 3;
   int   busy_cnt  = 0;

   int n_chk  = 0;
   int n_fail = 0;

   uart_tx_arb #(.N_REQ(N), .MAX_BURST(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .grant     (grant),
      .tx_data   (tx_data),
      .tx_start  (tx_start),
      .tx_busy   (tx_busy)
   );

   always #5 clk = ~clk;

   // Transmitter model: busy for busy_len cycles starting the cycle after tx_start.
   always @(posedge clk) begin
      if (tx_start)          busy_cnt <= busy_len;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end
   assign tx_busy = auto_busy ? (busy_cnt != 0) : man_busy;

   typedef struct {
      logic [3:0]  rv;
      logic [3:0]  rl;
      logic [31:0] rd;
      logic        busy;
      logic [3:0]  e_grant;
      logic [3:0]  e_ready;
      logic        e_start;
      logic [7:0]  e_data;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic [3:0] rv, input logic [3:0] rl, input logic [31:0] rd,
                      input logic busy, input logic [3:0] eg, input logic [3:0] er,
                      input logic es, input logic [7:0] ed);
      vec_t v;
      v.rv = rv; v.rl = rl; v.rd = rd; v.busy = busy;
      v.e_grant = eg; v.e_ready = er; v.e_start = es; v.e_data = ed;
      tbl.push_back(v);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      man_busy  = 1'b0;
      repeat (12) tick();
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] sd[4];
      logic [3:0] sg[4];
      logic [3:0] rprev4;
      int nst, k, nstart, gaps, gap_at, data_err, phase, zeros;
      logic saw_gap, rprev, got;

      // rv    rl    rd            busy  grant ready start data
      add(4'h0, 4'h0, 32'h00000000, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00);
      add(4'h1, 4'h1, 32'h000000A5, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00);
      add(4'h1, 4'h1, 32'h000000A5, 1'b0, 4'h1, 4'h1, 1'b0, 8'h00);
      add(4'h0, 4'h0, 32'h00000000, 1'b0, 4'h1, 4'h0, 1'b1, 8'hA5);
      add(4'h0, 4'h0, 32'h00000000, 1'b1, 4'h1, 4'h0, 1'b0, 8'hA5);
      add(4'h0, 4'h0, 32'h00000000, 1'b1, 4'h1, 4'h0, 1'b0, 8'hA5);
      add(4'h0, 4'h0, 32'h00000000, 1'b0, 4'h1, 4'h0, 1'b0, 8'hA5);
      add(4'h0, 4'h0, 32'h00000000, 1'b0, 4'h0, 4'h0, 1'b0, 8'hA5);
      // requester 1 abandons its packet in LOAD
      add(4'h2, 4'h0, 32'h00003C00, 1'b0, 4'h0, 4'h0, 1'b0, 8'hA5);
      add(4'h2, 4'h0, 32'h00003C00, 1'b0, 4'h2, 4'h2, 1'b0, 8'hA5);
      add(4'h2, 4'h0, 32'h00003D00, 1'b0, 4'h2, 4'h0, 1'b1, 8'h3C);
      add(4'h2, 4'h0, 32'h00003D00, 1'b1, 4'h2, 4'h0, 1'b0, 8'h3C);
      add(4'h2, 4'h0, 32'h00003D00, 1'b0, 4'h2, 4'h0, 1'b0, 8'h3C);
      add(4'h0, 4'h0, 32'h00000000, 1'b0, 4'h2, 4'h0, 1'b0, 8'h3C);
      add(4'h0, 4'h0, 32'h00000000, 1'b0, 4'h0, 4'h0, 1'b0, 8'h3C);
      // requester 3: transmitter busy on entering LOAD, then ack timeout
      add(4'h8, 4'h8, 32'h77000000, 1'b1, 4'h0, 4'h0, 1'b0, 8'h3C);
      add(4'h8, 4'h8, 32'h77000000, 1'b1, 4'h8, 4'h0, 1'b0, 8'h3C);
      add(4'h8, 4'h8, 32'h77000000, 1'b1, 4'h8, 4'h0, 1'b0, 8'h3C);
      add(4'h8, 4'h8, 32'h77000000, 1'b0, 4'h8, 4'h8, 1'b0, 8'h3C);
      add(4'h0, 4'h0, 32'h00000000, 1'b0, 4'h8, 4'h0, 1'b1, 8'h77);
      add(4'h0, 4'h0, 32'h00000000, 1'b0, 4'h8, 4'h0, 1'b0, 8'h77);
      add(4'h0, 4'h0, 32'h00000000, 1'b0, 4'h8, 4'h0, 1'b0, 8'h77);
      add(4'h0, 4'h0, 32'h00000000, 1'b0, 4'h8, 4'h0, 1'b0, 8'h77);
      add(4'h0, 4'h0, 32'h00000000, 1'b0, 4'h8, 4'h0, 1'b0, 8'h77);
      add(4'h0, 4'h0, 32'h00000000, 1'b0, 4'h0, 4'h0, 1'b0, 8'h77);

      auto_busy = 1'b0;
      do_reset();
      foreach (tbl[i]) begin
         tick();
         req_valid = tbl[i].rv;
         req_last  = tbl[i].rl;
         req_data  = tbl[i].rd;
         man_busy  = tbl[i].busy;
         #1;
         chk($sformatf("v%0d grant", i), 32'(grant), 32'(tbl[i].e_grant));
         chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(tbl[i].e_ready));
         chk($sformatf("v%0d tx_start", i), 32'(tx_start), 32'(tbl[i].e_start));
         chk($sformatf("v%0d tx_data", i), 32'(tx_data), 32'(tbl[i].e_data));
      end

      // All four request at once after reset: served 0,1,2,3.
      auto_busy = 1'b1;
      busy_len  = 3;
      do_reset();
      req_valid = 4'b1111;
      req_last  = 4'b1111;
      req_data  = 32'h13121110;
      rprev4    = '0;
      nst       = 0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         tick();
         req_valid = req_valid & ~rprev4;
         #1;
         rprev4 = req_ready;
         if (tx_start) begin
            if (nst < 4) begin
               sd[nst] = tx_data;
               sg[nst] = grant;
            end
            nst++;
         end
         if (nst >= 4 && grant == '0) break;
      end
      chk("rr start count", 32'(nst), 32'd4);
      for (int j = 0; j < 4; j++) begin
         chk($sformatf("rr data %0d", j), 32'(sd[j]), 32'(8'h10 + 8'(j)));
         chk($sformatf("rr grant %0d", j), 32'(sg[j]), 32'(4'b0001 << j));
      end

      // Requester 2, 20-byte packet: forced release after 16 bytes.
      do_reset();
      k         = 1;
      req_valid = 4'b0100;
      req_data  = {8'h00, 8'(k), 16'h0000};
      req_last  = 4'b0000;
      nstart = 0; gaps = 0; gap_at = 0; data_err = 0;
      saw_gap = 1'b0; rprev = 1'b0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         tick();
         if (rprev) begin
            k++;
            if (k > 20) req_valid = '0;
            req_data = {8'h00, 8'(k), 16'h0000};
            req_last = (k == 20) ? 4'b0100 : 4'b0000;
         end
         #1;
         rprev = req_ready[2];
         if (nstart > 0 && grant == '0) saw_gap = 1'b1;
         if (tx_start) begin
            nstart++;
            if (tx_data != 8'(nstart)) data_err++;
            if (saw_gap) begin
               gaps++;
               gap_at = nstart;
            end
            saw_gap = 1'b0;
         end
         if (nstart == 20 && grant == '0) break;
      end
      chk("burst byte count", 32'(nstart), 32'd20);
      chk("burst data errors", 32'(data_err), 32'd0);
      chk("burst release count", 32'(gaps), 32'd1);
      chk("burst release position", 32'(gap_at), 32'd17);
      chk("burst final grant", 32'(grant), 32'd0);
      req_valid = '0;

      // Back-to-back single-byte packets from requester 0: one idle cycle.
      busy_len = 2;
      do_reset();
      req_valid = 4'b0001;
      req_last  = 4'b0001;
      req_data  = 32'h00000042;
      phase = 0; zeros = 0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         tick();
         #1;
         if (phase == 0) begin
            if (grant == 4'b0001) phase = 1;
         end else if (phase == 1) begin
            if (grant == '0) begin
               phase = 2;
               zeros = 1;
            end
         end else begin
            if (grant == '0) zeros++;
            else break;
         end
      end
      chk("b2b regrant", 32'(grant), 32'h1);
      chk("b2b idle cycles", 32'(zeros), 32'd1);
      req_valid = '0;

      // Reset asserted in WAIT_DONE; requester 0 wins afterwards.
      busy_len = 6;
      do_reset();
      req_valid = 4'b0100;
      req_last  = 4'b0000;
      req_data  = 32'h00990000;
      got = 1'b0;
      for (int cyc = 0; cyc < 50; cyc++) begin
         tick();
         #1;
         if (tx_start) begin
            got = 1'b1;
            break;
         end
      end
      chk("rst seq tx_start seen", 32'(got), 32'd1);
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("rst seq grant before", 32'(grant), 32'h4);
      tick();
      rst       = 1'b0;
      req_valid = 4'b0101;
      req_last  = 4'b0101;
      req_data  = 32'h00990011;
      #1;
      chk("rst seq grant", 32'(grant), 32'h0);
      chk("rst seq req_ready", 32'(req_ready), 32'h0);
      chk("rst seq tx_start", 32'(tx_start), 32'h0);
      chk("rst seq tx_data", 32'(tx_data), 32'h0);
      tick();
      #1;
      chk("rst seq next grant", 32'(grant), 32'h1);
      chk("rst seq no start", 32'(tx_start), 32'h0);
      req_valid = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter MAX_BURST, default 16, maximum bytes per grant before forced release.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  N_REQ  byte available from requester i.
REQ-006 SHALL have port req_data  input  8*N_REQ  requester i byte at bits [8i+7:8i].
REQ-007 SHALL have port req_last  input  N_REQ  byte is final byte of requester i packet.
REQ-008 SHALL have port req_ready  output  N_REQ  byte of requester i accepted this cycle.
REQ-009 SHALL have port grant  output  N_REQ  one-hot owner of the transmitter; all-zero when idle.
REQ-010 SHALL have port tx_data  output  8  byte to transmitter core.
REQ-011 SHALL have port tx_start  output  1  one-cycle launch pulse to transmitter core.
REQ-012 SHALL have port tx_busy  input  1  transmitter core busy, high from cycle after tx_start until stop bit done.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, WAIT_ACK, WAIT_DONE.
REQ-014 IDLE: if any req_valid, SHALL register one-hot grant to round-robin winner, searching upward from (last owner + 1) mod N_REQ, then go LOAD; else stay.
REQ-015 Grant visible cycle t+1 after req_valid sampled in IDLE at cycle t.
REQ-016 LOAD, req_valid[g]=1 and tx_busy=0: req_ready[g]=1 combinationally that cycle; tx_data<=req_data[g], tx_start<=1 (registered, visible next cycle); capture req_last[g]; increment burst count; go WAIT_ACK.
REQ-017 LOAD, tx_busy=1: SHALL hold, req_ready all zero.
REQ-018 LOAD, req_valid[g]=0: SHALL release grant (grant<=0), update last owner to g, go IDLE (abandoned packet).
REQ-019 req_ready SHALL be zero in every state except REQ-016 case; at most one bit high.
REQ-020 tx_start SHALL be high exactly one cycle per accepted byte; tx_data SHALL hold its value until next accept.
REQ-021 WAIT_ACK: go WAIT_DONE when tx_busy=1; if tx_busy still 0 after 4 cycles, go WAIT_DONE anyway.
REQ-022 WAIT_DONE: when tx_busy=0, if captured last=1 or burst count==MAX_BURST, release grant, record last owner, clear burst count, go IDLE; else go LOAD keeping grant.
REQ-023 Burst count SHALL be $clog2(MAX_BURST+1) bits, never wraps; cleared on every release.
REQ-024 A requester raising req_valid while another holds grant SHALL not affect current grant; it is considered at next IDLE.
REQ-025 Simultaneous requests in IDLE: winner is first set bit at or above (last owner + 1), wrapping from N_REQ-1 to 0.
REQ-026 Back-to-back packets from one requester alone SHALL be granted consecutively with one IDLE cycle between.

Reset
REQ-027 On rst: state IDLE, grant 0, req_ready 0, tx_start 0, tx_data 8'h00, burst count 0, last owner N_REQ-1 (requester 0 wins first).
REQ-028 rst mid-transfer SHALL abort immediately; no further tx_start until new request after reset release.

Structure
REQ-029 FSM state enum and tx_busy ack-timeout constant (4) SHALL live in shared package uart_pkg.
REQ-030 Round-robin selection SHALL be sub-module rr_arbiter (combinational, inputs req vector and last owner, output one-hot winner).

Verification
REQ-031 Single req: req_valid=0001, data 8'hA5, last=1, tx_busy pulses 10 cycles -> grant 0001 at t+1, tx_start at t+2, tx_data A5, req_ready[0] one cycle, grant 0 after busy falls.
REQ-032 All four valid with last=1, last owner 3 -> grants in order 0,1,2,3, one byte each.
REQ-033 Requester 2 sends 20-byte packet (last only on byte 20), MAX_BURST=16 -> release after 16 bytes, re-granted, remaining 4 sent.
REQ-034 Requester 1 drops req_valid mid-packet in LOAD -> grant 0 next cycle, no tx_start.
REQ-035 tx_busy held high on entering LOAD -> req_ready 0 until busy falls; tx_busy never rising after tx_start -> WAIT_DONE after 4 cycles.
REQ-036 rst asserted during WAIT_DONE -> all outputs reset values next cycle; next grant goes to requester 0.
